// File: rtl/shift_reg_burst.sv
// Purpose : W-bit shift register with manual shift/rotate/load ops and a counted serial burst engine.
// Latency : one clk per op or burst bit; len == 0 burst reports done on the cycle after the start.
// Backpress: none; ce gates every step, and while ce is low all state holds and done drops.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   clr               synchronous clear, also aborts a burst silently
//   ce                bit-rate strobe gating loads, shifts and burst steps
//   mode[2:0]         manual op in IDLE: hold/shr/shl/ror/rol/load
//   d                 serial input bit
//   pdata[W-1:0]      parallel load value (manual load and burst start)
//   start, len, dir   burst request, length in bits (clamped to W), direction (1 = right)
//   q, so             register contents, serial output at the burst's exit end
//   busy, done        burst in progress, one-cycle completion pulse
module shift_reg_burst #(
   parameter  int W  = 8,
   localparam int LW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          ce,
   input  logic [2:0]    mode,
   input  logic          d,
   input  logic [W-1:0]  pdata,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          dir,
   output logic [W-1:0]  q,
   output logic          so,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;

   localparam logic [LW-1:0] W_LEN   = LW'(W);
   localparam logic [LW-1:0] CNT_ONE = LW'(1);

   state_t        state, state_nxt;
   logic [W-1:0]  q_nxt;
   logic [LW-1:0] cnt, cnt_nxt;
   logic          dir_r, dir_nxt;
   logic          done_nxt;
   logic [LW-1:0] len_clamped;

   assign len_clamped = (len > W_LEN) ? W_LEN : len;

   // State register: FSM state plus the datapath registers it steers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         dir_r <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         cnt   <= cnt_nxt;
         dir_r <= dir_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state logic. done_nxt is qualified with ~done so that a
   // zero-length start accepted during a done cycle cannot stretch the pulse.
   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      cnt_nxt   = cnt;
      dir_nxt   = dir_r;
      done_nxt  = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         q_nxt     = '0;
         cnt_nxt   = '0;
         dir_nxt   = 1'b0;
      end else if (ce) begin
         case (state)
            SHIFT: begin
               q_nxt   = dir_r ? {d, q[W-1:1]} : {q[W-2:0], d};
               cnt_nxt = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state_nxt = IDLE;
                  done_nxt  = ~done;
               end
            end
            default: begin
               if (start) begin
                  q_nxt   = pdata;
                  dir_nxt = dir;
                  cnt_nxt = len_clamped;
                  if (len_clamped == '0) done_nxt  = ~done;
                  else                   state_nxt = SHIFT;
               end else begin
                  case (mode)
                     MODE_SHR: begin
                        q_nxt   = {d, q[W-1:1]};
                        dir_nxt = 1'b1;
                     end
                     MODE_SHL: begin
                        q_nxt   = {q[W-2:0], d};
                        dir_nxt = 1'b0;
                     end
                     MODE_ROR: begin
                        q_nxt   = {q[0], q[W-1:1]};
                        dir_nxt = 1'b1;
                     end
                     MODE_ROL: begin
                        q_nxt   = {q[W-2:0], q[W-1]};
                        dir_nxt = 1'b0;
                     end
                     MODE_LOAD: q_nxt = pdata;
                     default:   q_nxt = q;
                  endcase
               end
            end
         endcase
      end
   end

   // Outputs: so taps whichever end the last direction shifts out of.
   always_comb begin
      busy = (state == SHIFT);
      so   = dir_r ? q[0] : q[W-1];
   end

endmodule

// File: tb/tb_shift_reg_burst.sv
// Purpose : self-checking bench for shift_reg_burst (W = 8).
// Latency : checks every output #1 after each rising edge against a reference model.
// Backpress: n/a; directed tables, hand sequences, then random stimulus.
module tb_shift_reg_burst;
   localparam int W  = 8;
   localparam int LW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst, clr, ce, d, start, dir;
   logic [2:0]    mode;
   logic [W-1:0]  pdata;
   logic [LW-1:0] len;
   logic [W-1:0]  q;
   logic          so, busy, done;

   int total = 0;
   int bad   = 0;

   // Reference model: register value, bits left in the burst, direction, done flag.
   logic [W-1:0] mq;
   int           rem;
   logic         mdir, mdone;

   typedef struct {
      logic          ce;
      logic [2:0]    mode;
      logic          d;
      logic [W-1:0]  pdata;
      logic          start;
      logic [LW-1:0] len;
      logic          dir;
      logic [W-1:0]  eq;
      logic          eb;
      logic          edn;
      logic          eso;
   } vec_t;

   vec_t tbl [15];

   shift_reg_burst #(.W(W)) dut (
      .clk(clk), .rst(rst), .clr(clr), .ce(ce), .mode(mode), .d(d),
      .pdata(pdata), .start(start), .len(len), .dir(dir),
      .q(q), .so(so), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq = '0; rem = 0; mdir = 1'b0; mdone = 1'b0;
   endtask

   // Behaviour per clock edge, from the rules: priority clr > ce > burst > start > mode.
   task automatic model_update();
      logic ev;
      ev = 1'b0;
      if (clr) begin
         model_reset();
      end else if (!ce) begin
         mdone = 1'b0;
      end else begin
         if (rem > 0) begin
            if (mdir) mq = (mq >> 1) | (W'(d) << (W - 1));
            else      mq = (mq << 1) | W'(d);
            rem = rem - 1;
            ev  = (rem == 0);
         end else if (start) begin
            mq   = pdata;
            mdir = dir;
            rem  = (int'(len) > W) ? W : int'(len);
            ev   = (rem == 0);
         end else begin
            case (mode)
               3'd1: begin mq = (mq >> 1) | (W'(d) << (W - 1)); mdir = 1'b1; end
               3'd2: begin mq = (mq << 1) | W'(d);              mdir = 1'b0; end
               3'd3: begin mq = (mq >> 1) | (mq << (W - 1));    mdir = 1'b1; end
               3'd4: begin mq = (mq << 1) | (mq >> (W - 1));    mdir = 1'b0; end
               3'd5: mq = pdata;
               default: ;
            endcase
         end
         mdone = ev && !mdone;
      end
   endtask

   task automatic cmp_model();
      check("model q",    q,    mq);
      check("model busy", busy, rem > 0);
      check("model done", done, mdone);
      check("model so",   so,   mdir ? mq[0] : mq[W-1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      cmp_model();
   endtask

   task automatic set_in(input logic i_clr, input logic i_ce, input logic [2:0] i_mode,
                         input logic i_d, input logic [W-1:0] i_pdata, input logic i_start,
                         input logic [LW-1:0] i_len, input logic i_dir);
      clr = i_clr; ce = i_ce; mode = i_mode; d = i_d;
      pdata = i_pdata; start = i_start; len = i_len; dir = i_dir;
   endtask

   initial begin
      logic [W-1:0] bits;
      int           n;

      // Directed table: shift-left fill, load, rotate right, then an MSB-first burst of 8'hA5.
      tbl[0]  = '{1'b1, 3'b010, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'b010, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'b010, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 3'b101, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 3'b011, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 3'b000, 1'b0, 8'hA5, 1'b1, 4'd8, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h4A, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h94, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h28, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h50, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      set_in(1'b0, 1'b0, 3'b000, 1'b0, '0, 1'b0, '0, 1'b0);
      model_reset();
      #12;
      check("reset q",    q,    0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset so",   so,   0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         set_in(1'b0, tbl[i].ce, tbl[i].mode, tbl[i].d, tbl[i].pdata,
                tbl[i].start, tbl[i].len, tbl[i].dir);
         tick();
         check($sformatf("vec%0d q", i),    q,    tbl[i].eq);
         check($sformatf("vec%0d busy", i), busy, tbl[i].eb);
         check($sformatf("vec%0d done", i), done, tbl[i].edn);
         check($sformatf("vec%0d so", i),   so,   tbl[i].eso);
      end

      // Same burst with ce on every other cycle: 16 busy cycles, each bit shown twice.
      bits = 8'hA5;
      set_in(1'b0, 1'b1, 3'b000, 1'b0, 8'hA5, 1'b1, 4'd8, 1'b0);
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         check($sformatf("half-rate so bit%0d", n), so, bits[7 - n / 2]);
         ce = n[0];
         n++;
         tick();
      end
      check("half-rate busy cycles", n, 16);
      check("half-rate done", done, 1);
      ce = 1'b1;
      tick();
      check("half-rate done once", done, 0);

      // clr after three burst shifts aborts without done.
      set_in(1'b0, 1'b1, 3'b000, 1'b0, 8'hA5, 1'b1, 4'd8, 1'b0);
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("pre-clr q", q, 8'h28);
      clr = 1'b1;
      tick();
      check("clr q",    q,    0);
      check("clr busy", busy, 0);
      check("clr done", done, 0);
      clr = 1'b0;
      tick();
      check("post-clr done", done, 0);

      // Zero-length burst: load only, done pulses once.
      set_in(1'b0, 1'b1, 3'b000, 1'b0, 8'h3C, 1'b1, 4'd0, 1'b1);
      tick();
      check("len0 q",    q,    8'h3C);
      check("len0 busy", busy, 0);
      check("len0 done", done, 1);
      start = 1'b0;
      tick();
      check("len0 done once", done, 0);

      // Over-long length clamps to W.
      set_in(1'b0, 1'b1, 3'b000, 1'b1, 8'h5A, 1'b1, 4'd12, 1'b1);
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 30) begin
         n++;
         tick();
      end
      check("len12 busy cycles", n, 8);
      check("len12 q", q, 8'hFF);

      // Asynchronous reset mid-burst takes effect before the next edge.
      set_in(1'b0, 1'b1, 3'b000, 1'b0, 8'hFF, 1'b1, 4'd8, 1'b1);
      tick();
      start = 1'b0;
      tick();
      #1;
      rst = 1'b1;
      #1;
      check("async rst q",    q,    0);
      check("async rst busy", busy, 0);
      check("async rst done", done, 0);
      check("async rst so",   so,   0);
      model_reset();
      rst = 1'b0;
      set_in(1'b0, 1'b1, 3'b010, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
      tick();
      check("first edge after rst q", q, 8'h01);

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         set_in(($urandom_range(39) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
                1'($urandom_range(1)), W'($urandom), ($urandom_range(5) == 0),
                LW'($urandom_range(15)), 1'($urandom_range(1)));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
